// File: rtl/ccd_dvp_rx_pkg.sv
// Shared types and helpers for the DVP pixel receiver.
package ccd_dvp_rx_pkg;

  typedef enum logic [2:0] {
    CDRX_ST_IDLE     = 3'd0,
    CDRX_ST_VSKIP    = 3'd1,
    CDRX_ST_HSKIP    = 3'd2,
    CDRX_ST_ACTIVE   = 3'd3,
    CDRX_ST_WAITLINE = 3'd4,
    CDRX_ST_DROP     = 3'd5
  } cdrx_state_t;

  // Convert a raw sync pin level to "asserted" (1) given the pin polarity.
  function automatic logic sync_act(input logic raw, input logic act_lo);
    return raw ^ act_lo;
  endfunction

endpackage

// File: rtl/ccd_dvp_rx_fifo.sv
// Show-ahead synchronous FIFO; full/empty from pointers with an extra wrap bit.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module ccd_dvp_rx_fifo #(
  parameter int W  = 18,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         full,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty
);
  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]  wp, rp;
  logic         push, pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop     = rd_en & ~empty;
  assign push    = wr_en & (~full | pop);
  // Head entry is forced to zero while empty so the outputs read 0 after reset.
  assign rd_data = empty ? '0 : mem[rp[AW-1:0]];

  // Read/write pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ccd_dvp_rx.sv
// DVP pixel receiver: registers the AFE bus, crops a window framed by
// hsync/vsync, and queues pixels as an AXI-Stream-style beat stream.
import ccd_dvp_rx_pkg::*;

module ccd_dvp_rx #(
  parameter int DW          = 16,
  parameter int CNTW        = 15,
  parameter int FIFO_AW     = 4,
  parameter bit SYNC_ACT_LO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [CNTW-1:0] hskip,
  input  logic [CNTW-1:0] hact,
  input  logic [CNTW-1:0] vskip,
  input  logic [CNTW-1:0] vact,
  input  logic            clr_err,
  input  logic            dvp_hsync,
  input  logic            dvp_vsync,
  input  logic [DW-1:0]   dvp_data,
  output logic [DW-1:0]   m_tdata,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic            m_tuser,
  output logic            m_tlast,
  output logic            frame_done,
  output logic            busy,
  output logic            err_ovf,
  output logic            err_short
);
  logic            hs_r, vs_r, hs_d, vs_d, hs_a, vs_a, hs_edge, vs_edge;
  logic [DW-1:0]   data_r;
  logic [CNTW-1:0] hskip_c, hact_m1, vskip_c, vact_m1;
  cdrx_state_t     state, state_n, line_st;
  logic [CNTW-1:0] hcnt, hcnt_n, vcnt, vcnt_n;
  logic            sof, sof_n, last_line;
  logic            cap, cap_last, cap_eof, cut;
  logic            pend_vld, pend_user, pend_last, pend_eof;
  logic [DW-1:0]   pend_data;
  logic            flush, ovf, full, empty;
  logic [DW+1:0]   wr_data, rd_data;

  assign hs_a    = sync_act(hs_r, SYNC_ACT_LO);
  assign vs_a    = sync_act(vs_r, SYNC_ACT_LO);
  assign hs_edge = hs_a & ~hs_d;
  assign vs_edge = vs_a & ~vs_d;

  // Input register stage plus delayed active-level copies for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_r   <= SYNC_ACT_LO;
      vs_r   <= SYNC_ACT_LO;
      hs_d   <= 1'b0;
      vs_d   <= 1'b0;
      data_r <= '0;
    end else begin
      hs_r   <= dvp_hsync;
      vs_r   <= dvp_vsync;
      hs_d   <= hs_a;
      vs_d   <= vs_a;
      data_r <= dvp_data;
    end
  end

  // Window config, frozen for the frame at each vsync assert edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hskip_c <= '0;
      hact_m1 <= '0;
      vskip_c <= '0;
      vact_m1 <= '0;
    end else if (vs_edge) begin
      hskip_c <= hskip;
      hact_m1 <= (hact == '0) ? '0 : hact - 1'b1;
      vskip_c <= vskip;
      vact_m1 <= (vact == '0) ? '0 : vact - 1'b1;
    end
  end

  assign line_st   = (hskip_c == '0) ? CDRX_ST_ACTIVE : CDRX_ST_HSKIP;
  assign last_line = (vcnt == vact_m1);

  // Next-state, counters and capture/cut strobes
  always_comb begin
    state_n  = state;
    hcnt_n   = hcnt;
    vcnt_n   = vcnt;
    sof_n    = sof;
    cap      = 1'b0;
    cap_last = 1'b0;
    cap_eof  = 1'b0;
    cut      = 1'b0;
    if (vs_edge) begin
      // DROP's exit edge is the expected recovery, not a truncation.
      cut     = (state != CDRX_ST_IDLE) && (state != CDRX_ST_DROP);
      state_n = en ? CDRX_ST_VSKIP : CDRX_ST_IDLE;
      hcnt_n  = '0;
      vcnt_n  = '0;
      sof_n   = en;
    end else begin
      case (state)
        CDRX_ST_VSKIP: begin
          if (hs_edge) begin
            if (vcnt == vskip_c) begin
              vcnt_n  = '0;
              hcnt_n  = '0;
              state_n = line_st;
            end else begin
              vcnt_n = vcnt + 1'b1;
            end
          end
        end
        CDRX_ST_HSKIP, CDRX_ST_ACTIVE: begin
          if (hs_edge) begin
            // Early hsync: the truncated line still counts toward vact.
            cut    = 1'b1;
            hcnt_n = '0;
            if (last_line) begin
              state_n = CDRX_ST_IDLE;
            end else begin
              vcnt_n  = vcnt + 1'b1;
              state_n = line_st;
            end
          end else if (state == CDRX_ST_HSKIP) begin
            if (hcnt == hskip_c - 1'b1) begin
              hcnt_n  = '0;
              state_n = CDRX_ST_ACTIVE;
            end else begin
              hcnt_n = hcnt + 1'b1;
            end
          end else begin
            cap   = 1'b1;
            sof_n = 1'b0;
            if (hcnt == hact_m1) begin
              cap_last = 1'b1;
              cap_eof  = last_line;
              hcnt_n   = '0;
              if (last_line) begin
                state_n = CDRX_ST_IDLE;
              end else begin
                vcnt_n  = vcnt + 1'b1;
                state_n = CDRX_ST_WAITLINE;
              end
            end else begin
              hcnt_n = hcnt + 1'b1;
            end
          end
        end
        CDRX_ST_WAITLINE: begin
          if (hs_edge) begin
            hcnt_n  = '0;
            state_n = line_st;
          end
        end
        default: ;
      endcase
    end
  end

  // The held pixel leaves when a new one arrives, its line ends, or a sync cuts it off.
  assign flush      = pend_vld & (pend_last | cut | cap);
  assign wr_data    = {pend_user, pend_last | cut, pend_data};
  assign ovf        = flush & full & ~m_tready;
  assign frame_done = flush & pend_eof & ~ovf;

  // State register, counters and pending-pixel register; overflow forces DROP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CDRX_ST_IDLE;
      hcnt      <= '0;
      vcnt      <= '0;
      sof       <= 1'b0;
      pend_vld  <= 1'b0;
      pend_user <= 1'b0;
      pend_last <= 1'b0;
      pend_eof  <= 1'b0;
      pend_data <= '0;
    end else begin
      state <= (ovf && !vs_edge) ? CDRX_ST_DROP : state_n;
      hcnt  <= hcnt_n;
      vcnt  <= vcnt_n;
      sof   <= sof_n;
      if (cap && !ovf) begin
        pend_vld  <= 1'b1;
        pend_user <= sof;
        pend_last <= cap_last;
        pend_eof  <= cap_eof;
        pend_data <= data_r;
      end else if (flush) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // Sticky error flags; a new error outranks a clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf   <= 1'b0;
      err_short <= 1'b0;
    end else begin
      if (ovf)          err_ovf <= 1'b1;
      else if (clr_err) err_ovf <= 1'b0;
      if (cut)          err_short <= 1'b1;
      else if (clr_err) err_short <= 1'b0;
    end
  end

  assign busy = (state != CDRX_ST_IDLE);

  ccd_dvp_rx_fifo #(.W(DW + 2), .AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (flush),
    .wr_data (wr_data),
    .full    (full),
    .rd_en   (m_tready),
    .rd_data (rd_data),
    .empty   (empty)
  );

  assign m_tvalid = ~empty;
  assign m_tuser  = rd_data[DW+1];
  assign m_tlast  = rd_data[DW];
  assign m_tdata  = rd_data[DW-1:0];

endmodule

// File: tb/tb_ccd_dvp_rx.sv
// Scenario bench for ccd_dvp_rx: expected beats are queued as pixels are driven
// and compared as the DUT hands them out.
module tb_ccd_dvp_rx;
  localparam int DW   = 16;
  localparam int CNTW = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0, clr_err = 1'b0, m_tready = 1'b1;
  logic            dvp_hsync = 1'b1, dvp_vsync = 1'b1;
  logic [DW-1:0]   dvp_data = '0;
  logic [CNTW-1:0] hskip = '0, hact = '0, vskip = '0, vact = '0;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid, m_tuser, m_tlast, frame_done, busy, err_ovf, err_short;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          user;
    logic          last;
  } beat_t;

  beat_t         sbq[$];
  beat_t         exp_b;
  int            checks = 0, failures = 0, beats = 0, fd_cnt = 0;
  logic [DW-1:0] pv = '0;
  bit            first = 1'b0;

  always #5 clk = ~clk;

  ccd_dvp_rx dut (
    .clk(clk), .rst(rst), .en(en), .hskip(hskip), .hact(hact), .vskip(vskip), .vact(vact),
    .clr_err(clr_err), .dvp_hsync(dvp_hsync), .dvp_vsync(dvp_vsync), .dvp_data(dvp_data),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tuser(m_tuser),
    .m_tlast(m_tlast), .frame_done(frame_done), .busy(busy), .err_ovf(err_ovf),
    .err_short(err_short)
  );

  // Scoreboard consumer: every accepted beat must match the head of the queue
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      beats++;
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected got data=%h user=%b last=%b", m_tdata, m_tuser, m_tlast);
      end else begin
        exp_b = sbq.pop_front();
        if ({m_tdata, m_tuser, m_tlast} !== exp_b) begin
          failures++;
          $display("FAIL beat got data=%h user=%b last=%b want data=%h user=%b last=%b",
                   m_tdata, m_tuser, m_tlast, exp_b.data, exp_b.user, exp_b.last);
        end
      end
    end
    if (!rst && frame_done) fd_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // One pixel clock of stimulus (sync levels given as "asserted", pins are active low)
  task automatic cyc(input bit hs, input bit vs);
    dvp_hsync = ~hs;
    dvp_vsync = ~vs;
    dvp_data  = pv;
    @(posedge clk); #1;
    pv = pv + 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    cyc(1'b0, 1'b0);
    clr_err = 1'b0;
  endtask

  // A line: hsync asserted on j=0..1; pixels j=hskip+1 .. hskip+ncap are expected
  task automatic send_line(input int len, input int ncap, input bit cap);
    int hs_i;
    hs_i = int'(hskip);
    for (int j = 0; j < len; j++) begin
      if (cap && j >= hs_i + 1 && j < hs_i + 1 + ncap) begin
        sbq.push_back(beat_t'{data: pv, user: first, last: (j == hs_i + ncap)});
        first = 1'b0;
      end
      cyc(j < 2, 1'b0);
    end
  endtask

  task automatic frame_start(input bit cap);
    first = cap;
    for (int i = 0; i < 4; i++) cyc(1'b0, i < 2);
  endtask

  task automatic frame_body(input int len, input bit cap);
    int ha, va;
    ha = (hact == '0) ? 1 : int'(hact);
    va = (vact == '0) ? 1 : int'(vact);
    for (int i = 0; i < int'(vskip); i++) send_line(len, 0, 1'b0);
    for (int i = 0; i < va; i++) send_line(len, ha, cap);
    idle(6);
  endtask

  task automatic send_frame(input int len, input bit cap);
    frame_start(cap);
    frame_body(len, cap);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      cyc(1'b0, 1'b0);
      n++;
    end
    idle(3);
    checks++;
    if (sbq.size() != 0 || m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain left=%0d tvalid=%b want 0 and 0", name, sbq.size(), m_tvalid);
    end
  endtask

  task automatic nominal_cfg();
    hskip = 15'd2; hact = 15'd8; vskip = 15'd1; vact = 15'd3; en = 1'b1; m_tready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if ({m_tvalid, m_tuser, m_tlast, m_tdata, frame_done, busy, err_ovf, err_short} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b user=%b last=%b data=%h fd=%b busy=%b ovf=%b short=%b want all 0",
               m_tvalid, m_tuser, m_tlast, m_tdata, frame_done, busy, err_ovf, err_short);
    end
    rst = 1'b0;
    idle(3);
  endtask

  task automatic test_nominal();
    int b0, f0;
    nominal_cfg();
    b0 = beats; f0 = fd_cnt;
    send_frame(16, 1'b1);
    drain("nominal");
    checks++;
    if (beats - b0 != 24) begin failures++; $display("FAIL nominal_beats got %0d want 24", beats - b0); end
    checks++;
    if (fd_cnt - f0 != 1) begin failures++; $display("FAIL nominal_frame_done got %0d want 1", fd_cnt - f0); end
    checks++;
    if ({busy, err_ovf, err_short} !== 3'b000) begin
      failures++;
      $display("FAIL nominal_status got busy=%b ovf=%b short=%b want 0 0 0", busy, err_ovf, err_short);
    end
  endtask

  task automatic test_zero_cfg();
    int b0, f0;
    hskip = '0; hact = '0; vskip = '0; vact = '0; en = 1'b1;
    b0 = beats; f0 = fd_cnt;
    send_frame(8, 1'b1);
    drain("zero_cfg");
    checks++;
    if (beats - b0 != 1 || fd_cnt - f0 != 1) begin
      failures++;
      $display("FAIL zero_cfg got beats=%0d fd=%0d want 1 1", beats - b0, fd_cnt - f0);
    end
  endtask

  task automatic test_short_line();
    int b0, f0;
    nominal_cfg();
    pulse_clr();
    b0 = beats; f0 = fd_cnt;
    frame_start(1'b1);
    send_line(16, 0, 1'b0);
    send_line(int'(hskip) + 6, 5, 1'b1);
    send_line(16, 8, 1'b1);
    send_line(16, 8, 1'b1);
    idle(6);
    drain("short_line");
    checks++;
    if (beats - b0 != 21) begin failures++; $display("FAIL short_line_beats got %0d want 21", beats - b0); end
    checks++;
    if (err_short !== 1'b1 || fd_cnt - f0 != 1) begin
      failures++;
      $display("FAIL short_line_flags got short=%b fd=%0d want 1 1", err_short, fd_cnt - f0);
    end
  endtask

  task automatic test_midframe_vsync();
    int b0, f0;
    nominal_cfg();
    pulse_clr();
    b0 = beats; f0 = fd_cnt;
    frame_start(1'b1);
    send_line(16, 0, 1'b0);
    send_line(16, 8, 1'b1);
    send_line(int'(hskip) + 5, 4, 1'b1);
    send_frame(16, 1'b1);
    drain("midframe");
    checks++;
    if (beats - b0 != 36) begin failures++; $display("FAIL midframe_beats got %0d want 36", beats - b0); end
    checks++;
    if (err_short !== 1'b1 || fd_cnt - f0 != 1) begin
      failures++;
      $display("FAIL midframe_flags got short=%b fd=%0d want 1 1", err_short, fd_cnt - f0);
    end
  endtask

  task automatic test_overflow();
    int b0, f0;
    nominal_cfg();
    pulse_clr();
    b0 = beats; f0 = fd_cnt;
    m_tready = 1'b0;
    frame_start(1'b1);
    send_line(16, 0, 1'b0);
    send_line(16, 8, 1'b1);
    send_line(16, 8, 1'b1);
    send_line(16, 8, 1'b0);
    idle(4);
    checks++;
    if ({err_ovf, busy, m_tvalid} !== 3'b111) begin
      failures++;
      $display("FAIL ovf_flags got ovf=%b busy=%b tvalid=%b want 1 1 1", err_ovf, busy, m_tvalid);
    end
    m_tready = 1'b1;
    drain("ovf");
    checks++;
    if (beats - b0 != 16 || fd_cnt - f0 != 0) begin
      failures++;
      $display("FAIL ovf_beats got beats=%0d fd=%0d want 16 0", beats - b0, fd_cnt - f0);
    end
    b0 = beats; f0 = fd_cnt;
    frame_start(1'b1);
    pulse_clr();
    frame_body(16, 1'b1);
    drain("ovf_recover");
    checks++;
    if (beats - b0 != 24 || fd_cnt - f0 != 1 || {err_ovf, err_short} !== 2'b00) begin
      failures++;
      $display("FAIL ovf_recover got beats=%0d fd=%0d ovf=%b short=%b want 24 1 0 0",
               beats - b0, fd_cnt - f0, err_ovf, err_short);
    end
  endtask

  task automatic test_en_toggle();
    int b0, f0;
    nominal_cfg();
    b0 = beats; f0 = fd_cnt;
    frame_start(1'b1);
    send_line(16, 0, 1'b0);
    send_line(16, 8, 1'b1);
    en = 1'b0;
    send_line(16, 8, 1'b1);
    send_line(16, 8, 1'b1);
    idle(6);
    drain("en_toggle");
    checks++;
    if (beats - b0 != 24 || fd_cnt - f0 != 1) begin
      failures++;
      $display("FAIL en_toggle_frame got beats=%0d fd=%0d want 24 1", beats - b0, fd_cnt - f0);
    end
    b0 = beats; f0 = fd_cnt;
    frame_start(1'b0);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL en_off_busy got %b want 0", busy); end
    frame_body(16, 1'b0);
    drain("en_off");
    checks++;
    if (beats - b0 != 0 || fd_cnt - f0 != 0) begin
      failures++;
      $display("FAIL en_off_frame got beats=%0d fd=%0d want 0 0", beats - b0, fd_cnt - f0);
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int b0, f0;
    nominal_cfg();
    m_tready = 1'b0;
    frame_start(1'b0);
    send_line(16, 0, 1'b0);
    for (int j = 0; j < 7; j++) cyc(j < 2, 1'b0);
    checks++;
    if ({m_tvalid, busy} !== 2'b11) begin
      failures++;
      $display("FAIL pre_reset got tvalid=%b busy=%b want 1 1", m_tvalid, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({m_tvalid, m_tuser, m_tlast, m_tdata, frame_done, busy, err_ovf, err_short} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got valid=%b user=%b last=%b data=%h fd=%b busy=%b ovf=%b short=%b want all 0",
               m_tvalid, m_tuser, m_tlast, m_tdata, frame_done, busy, err_ovf, err_short);
    end
    sbq.delete();
    idle(2);
    rst = 1'b0;
    m_tready = 1'b1;
    idle(2);
    b0 = beats; f0 = fd_cnt;
    send_frame(16, 1'b1);
    drain("reset_mid");
    checks++;
    if (beats - b0 != 24 || fd_cnt - f0 != 1) begin
      failures++;
      $display("FAIL reset_mid_frame got beats=%0d fd=%0d want 24 1", beats - b0, fd_cnt - f0);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_cfg();
    test_short_line();
    test_midframe_vsync();
    test_overflow();
    test_en_toggle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
